// File: rtl/pipeline_stage_registers.sv
// ============================================================================
// Module : pipeline_stage_registers (package)
// Brief  : Shared IF/ID and ID/EX stage records, ALU op and RV32I opcodes
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_stage_registers;

  localparam logic [6:0] c_OPC_LUI     = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL     = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR    = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE   = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] c_OPC_OP      = 7'b0110011;
  localparam logic [6:0] c_OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] fetched_inst;
  } IF_ID;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic        valid;
  } ID_EX;

  // alt selects SUB/SRA (funct7[5]) where the encoding allows it
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// Module : imm_gen
// Brief  : Combinational RV32I immediate extraction and sign extension
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_gen
  import pipeline_stage_registers::*;
(
  input  logic [31:0] inst_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  logic w_unused;
  assign w_unused = ^inst_i[6:0];

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      IMM_U:   imm_o = {inst_i[31:12], 12'b0};
      IMM_J:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decode_unit.sv
// ============================================================================
// Module : decode_unit
// Brief  : RV32I decode stage with write-back bypass and load-use stall
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_unit
  import pipeline_stage_registers::*;
(
  input  logic        clk,
  input  logic        reset,
  input  IF_ID        if_id_reg,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        hazard_stall,
  output ID_EX        id_ex_reg
);

  ID_EX        id_ex_q, id_ex_d;
  ID_EX        w_dec;
  logic [31:0] w_inst, w_imm, w_rs1_val, w_rs2_val;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  imm_fmt_e    w_fmt;
  alu_op_e     w_alu;
  logic        w_legal, w_rw, w_mr, w_mw, w_br, w_jp;
  logic        w_use_rs1, w_use_rs2, w_rd_zero, w_bubble;

  assign w_inst   = if_id_reg.fetched_inst;
  assign w_opc    = w_inst[6:0];
  assign w_rd     = w_inst[11:7];
  assign w_f3     = w_inst[14:12];
  assign w_rs1    = w_inst[19:15];
  assign w_rs2    = w_inst[24:20];
  assign w_f7     = w_inst[31:25];
  assign w_bubble = (w_inst == 32'd0);

  assign rf_rs1_addr = w_rs1;
  assign rf_rs2_addr = w_rs2;

  // x0 always reads zero; otherwise the write-back value wins over the array
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                     (wb_we && (wb_rd == w_rs1)) ? wb_data : rf_rs1_data;
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 :
                     (wb_we && (wb_rd == w_rs2)) ? wb_data : rf_rs2_data;

  imm_gen u_imm_gen (
    .inst_i (w_inst),
    .fmt_i  (w_fmt),
    .imm_o  (w_imm)
  );

  always_comb begin
    w_fmt     = IMM_NONE;
    w_alu     = ALU_ADD;
    w_legal   = 1'b0;
    w_rw      = 1'b0;
    w_mr      = 1'b0;
    w_mw      = 1'b0;
    w_br      = 1'b0;
    w_jp      = 1'b0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    w_rd_zero = 1'b0;
    case (w_opc)
      c_OPC_LUI: begin
        w_legal = 1'b1; w_fmt = IMM_U; w_alu = ALU_PASSB; w_rw = 1'b1; w_use_rs1 = 1'b0;
      end
      c_OPC_AUIPC: begin
        w_legal = 1'b1; w_fmt = IMM_U; w_rw = 1'b1; w_use_rs1 = 1'b0;
      end
      c_OPC_JAL: begin
        w_legal = 1'b1; w_fmt = IMM_J; w_rw = 1'b1; w_jp = 1'b1; w_use_rs1 = 1'b0;
      end
      c_OPC_JALR: begin
        w_legal = (w_f3 == 3'b000); w_fmt = IMM_I; w_rw = 1'b1; w_jp = 1'b1;
      end
      c_OPC_BRANCH: begin
        w_legal   = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_fmt     = IMM_B; w_br = 1'b1; w_use_rs2 = 1'b1; w_rd_zero = 1'b1;
        w_alu     = (w_f3[2:1] == 2'b00) ? ALU_SUB :
                    (w_f3[1] ? ALU_SLTU : ALU_SLT);
      end
      c_OPC_LOAD: begin
        w_legal = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        w_fmt   = IMM_I; w_rw = 1'b1; w_mr = 1'b1;
      end
      c_OPC_STORE: begin
        w_legal = w_f3 inside {3'b000, 3'b001, 3'b010};
        w_fmt   = IMM_S; w_mw = 1'b1; w_use_rs2 = 1'b1; w_rd_zero = 1'b1;
      end
      c_OPC_OPIMM: begin
        case (w_f3)
          3'b001:  w_legal = (w_f7 == 7'b0000000);
          3'b101:  w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          default: w_legal = 1'b1;
        endcase
        w_fmt = IMM_I; w_rw = 1'b1;
        w_alu = alu_from_f3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
      end
      c_OPC_OP: begin
        w_legal = (w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_rw = 1'b1; w_use_rs2 = 1'b1;
        w_alu = alu_from_f3(w_f3, w_f7[5]);
      end
      c_OPC_MISCMEM: w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001);
      c_OPC_SYSTEM:  w_legal = (w_f3 != 3'b100);
      default:       w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_dec = '0;
    if (!w_bubble) begin
      w_dec.valid     = 1'b1;
      w_dec.illegal   = !w_legal;
      w_dec.pc        = if_id_reg.pc;
      w_dec.rd        = w_rd_zero ? 5'd0 : w_rd;
      w_dec.rs1       = w_rs1;
      w_dec.rs2       = w_rs2;
      w_dec.funct3    = w_f3;
      w_dec.alu_op    = w_legal ? w_alu : ALU_ADD;
      w_dec.imm       = w_imm;
      w_dec.rs1_val   = w_rs1_val;
      w_dec.rs2_val   = w_rs2_val;
      w_dec.reg_write = w_legal && w_rw && !w_rd_zero && (w_rd != 5'd0);
      w_dec.mem_read  = w_legal && w_mr;
      w_dec.mem_write = w_legal && w_mw;
      w_dec.branch    = w_legal && w_br;
      w_dec.jump      = w_legal && w_jp;
    end
  end

  // Load-use: the load in execute has not produced its data yet
  assign hazard_stall = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                        !w_bubble &&
                        ((w_use_rs1 && (w_rs1 == id_ex_q.rd)) ||
                         (w_use_rs2 && (w_rs2 == id_ex_q.rd)));

  always_comb begin
    id_ex_d = w_dec;
    if (flush)             id_ex_d = '0;
    else if (stall)        id_ex_d = id_ex_q;
    else if (hazard_stall) id_ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  assign id_ex_reg = id_ex_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_unit.sv
// ============================================================================
// Module : tb_decode_unit
// Brief  : Directed self-checking bench for decode_unit
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_unit;
  import pipeline_stage_registers::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, wb_we, hazard_stall;
  IF_ID        if_id_reg;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, wb_rd;
  logic [31:0] rf_rs1_data, rf_rs2_data, wb_data;
  ID_EX        id_ex_reg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_unit dut (
    .clk          (clk),
    .reset        (reset),
    .if_id_reg    (if_id_reg),
    .stall        (stall),
    .flush        (flush),
    .rf_rs1_addr  (rf_rs1_addr),
    .rf_rs2_addr  (rf_rs2_addr),
    .rf_rs1_data  (rf_rs1_data),
    .rf_rs2_data  (rf_rs2_data),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .hazard_stall (hazard_stall),
    .id_ex_reg    (id_ex_reg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    if_id_reg.fetched_inst = inst;
    if_id_reg.pc           = pc;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    n_cmp++;
    assert (id_ex_reg === '0) else begin
      n_bad++;
      $error("FAIL %s observed=0x%h expected=all-zero", tag, id_ex_reg);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    if_id_reg = '0; rf_rs1_data = '0; rf_rs2_data = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    chk_zero("reset_idex");
    chk("reset_hazard", 32'(hazard_stall), 32'd0);

    // addi x1,x0,5 with garbage on the rs1 read port: x0 must read zero
    reset = 1'b0;
    present(32'h0050_0093, 32'h0000_0100);
    rf_rs1_data = 32'h1234_5678;
    #1 chk("addi_rs1_addr", 32'(rf_rs1_addr), 32'd0);
    tick();
    chk("addi_valid", 32'(id_ex_reg.valid), 32'd1);
    chk("addi_rd", 32'(id_ex_reg.rd), 32'd1);
    chk("addi_rs1", 32'(id_ex_reg.rs1), 32'd0);
    chk("addi_imm", id_ex_reg.imm, 32'd5);
    chk("addi_rw", 32'(id_ex_reg.reg_write), 32'd1);
    chk("addi_rs1val", id_ex_reg.rs1_val, 32'd0);
    chk("addi_pc", id_ex_reg.pc, 32'h0000_0100);
    chk("addi_alu", 32'(id_ex_reg.alu_op), 32'(ALU_ADD));

    // lw x2,0(x1) followed by add x3,x2,x1 -> one bubble
    present(32'h0000_A103, 32'h0000_0104);
    rf_rs1_data = 32'h0000_1000;
    tick();
    chk("lw_mr", 32'(id_ex_reg.mem_read), 32'd1);
    chk("lw_rd", 32'(id_ex_reg.rd), 32'd2);
    chk("lw_rs1val", id_ex_reg.rs1_val, 32'h0000_1000);
    chk("lw_rw", 32'(id_ex_reg.reg_write), 32'd1);
    present(32'h0011_01B3, 32'h0000_0108);
    rf_rs1_data = 32'd7; rf_rs2_data = 32'd9;
    #1 chk("lu_hazard_on", 32'(hazard_stall), 32'd1);
    tick();
    chk_zero("lu_bubble");
    chk("lu_hazard_off", 32'(hazard_stall), 32'd0);
    tick();
    chk("add_valid", 32'(id_ex_reg.valid), 32'd1);
    chk("add_rs1", 32'(id_ex_reg.rs1), 32'd2);
    chk("add_rs2", 32'(id_ex_reg.rs2), 32'd1);
    chk("add_rd", 32'(id_ex_reg.rd), 32'd3);
    chk("add_rs1val", id_ex_reg.rs1_val, 32'd7);
    chk("add_rs2val", id_ex_reg.rs2_val, 32'd9);

    // add x4,x1,x2 with write-back bypass on x1, then on x0
    present(32'h0020_8233, 32'h0000_010C);
    rf_rs1_data = 32'd0; rf_rs2_data = 32'h55;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF;
    tick();
    chk("byp_rs1val", id_ex_reg.rs1_val, 32'hDEAD_BEEF);
    chk("byp_rs2val", id_ex_reg.rs2_val, 32'h55);
    wb_rd = 5'd0;
    tick();
    chk("byp_x0_rs1val", id_ex_reg.rs1_val, 32'd0);
    wb_rd = 5'd2;
    tick();
    chk("byp_rs2_hit", id_ex_reg.rs2_val, 32'hDEAD_BEEF);
    wb_we = 1'b0;

    // beq x0,x0,-8
    present(32'hFE00_0CE3, 32'h0000_0110);
    tick();
    chk("beq_branch", 32'(id_ex_reg.branch), 32'd1);
    chk("beq_imm", id_ex_reg.imm, 32'hFFFF_FFF8);
    chk("beq_rw", 32'(id_ex_reg.reg_write), 32'd0);
    chk("beq_rd", 32'(id_ex_reg.rd), 32'd0);
    chk("beq_alu", 32'(id_ex_reg.alu_op), 32'(ALU_SUB));

    // flush wins over stall
    present(32'h0050_0093, 32'h0000_0200);
    flush = 1'b1; stall = 1'b1;
    tick();
    chk_zero("flush_stall");
    flush = 1'b0; stall = 1'b0;
    tick();
    chk("pre_stall_valid", 32'(id_ex_reg.valid), 32'd1);

    // stall alone holds addi while lui x5,0x12345 waits upstream
    present(32'h1234_52B7, 32'h0000_0204);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rd", 32'(id_ex_reg.rd), 32'd1);
      chk("stall_imm", id_ex_reg.imm, 32'd5);
      chk("stall_pc", id_ex_reg.pc, 32'h0000_0200);
    end
    stall = 1'b0;
    tick();
    chk("lui_rd", 32'(id_ex_reg.rd), 32'd5);
    chk("lui_imm", id_ex_reg.imm, 32'h1234_5000);
    chk("lui_alu", 32'(id_ex_reg.alu_op), 32'(ALU_PASSB));

    // jal x1,-4
    present(32'hFFDF_F0EF, 32'h0000_0208);
    tick();
    chk("jal_jump", 32'(id_ex_reg.jump), 32'd1);
    chk("jal_imm", id_ex_reg.imm, 32'hFFFF_FFFC);
    chk("jal_rw", 32'(id_ex_reg.reg_write), 32'd1);

    // sw x2,4(x1)
    present(32'h0020_A223, 32'h0000_020C);
    tick();
    chk("sw_mw", 32'(id_ex_reg.mem_write), 32'd1);
    chk("sw_imm", id_ex_reg.imm, 32'd4);
    chk("sw_rd", 32'(id_ex_reg.rd), 32'd0);
    chk("sw_rw", 32'(id_ex_reg.reg_write), 32'd0);

    // undefined opcode
    present(32'hFFFF_FFFF, 32'h0000_0210);
    tick();
    chk("ill_valid", 32'(id_ex_reg.valid), 32'd1);
    chk("ill_flag", 32'(id_ex_reg.illegal), 32'd1);
    chk("ill_flags", {27'd0, id_ex_reg.reg_write, id_ex_reg.mem_read,
                      id_ex_reg.mem_write, id_ex_reg.branch, id_ex_reg.jump}, 32'd0);

    // OP with funct7=0000001 is not RV32I
    present(32'h0220_8233, 32'h0000_0214);
    tick();
    chk("f7_illegal", 32'(id_ex_reg.illegal), 32'd1);
    chk("f7_rw", 32'(id_ex_reg.reg_write), 32'd0);

    // reset mid-stream
    present(32'h0050_0093, 32'h0000_0300);
    tick();
    chk("mid_valid", 32'(id_ex_reg.valid), 32'd1);
    reset = 1'b1;
    present(32'h0000_A103, 32'h0000_0304);
    tick();
    chk_zero("mid_reset");
    present(32'h0011_01B3, 32'h0000_0308);
    tick();
    chk("mid_reset_hazard", 32'(hazard_stall), 32'd0);
    chk_zero("mid_reset_hold");
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 if_id_reg  in  IF_ID  fetched instruction and its pc from the fetch stage.
REQ-004 stall  in  1  downstream back-pressure; hold id_ex_reg.
REQ-005 flush  in  1  branch/jump redirect; kill the instruction in decode.
REQ-006 rf_rs1_addr, rf_rs2_addr  out  5 each  combinational register-file read addresses (inst[19:15], inst[24:20]).
REQ-007 rf_rs1_data, rf_rs2_data  in  32 each  register-file read data, same cycle.
REQ-008 wb_we  in  1, wb_rd  in  5, wb_data  in  32: write-back port, used for bypass.
REQ-009 hazard_stall  out  1  combinational load-use stall request to fetch/PC stages.
REQ-010 id_ex_reg  out  ID_EX  registered decoded instruction for execute.

Function
REQ-011 Latency: one cycle; id_ex_reg reflects the if_id_reg presented on the previous edge.
REQ-012 Bubble: all-zero fetched_inst is a bubble; id_ex_reg.valid=0, all control flags 0.
REQ-013 Decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (as NOP), SYSTEM (as NOP).
REQ-014 Any other opcode, or invalid funct3/funct7 for its opcode: valid=1, illegal=1, reg_write/mem_read/mem_write/branch/jump=0.
REQ-015 Fields: pc, rd, rs1, rs2, funct3, alu_op, imm, rs1_val, rs2_val, reg_write, mem_read, mem_write, branch, jump, illegal, valid.
REQ-016 imm sign-extended to 32 bits per I/S/B/U/J format; B and J immediates have bit 0 = 0; U immediate = inst[31:12]<<12.
REQ-017 rd forced to 0 and reg_write=0 for BRANCH and STORE; reg_write=0 whenever decoded rd==0.
REQ-018 Bypass: rs1_val = wb_data if wb_we and wb_rd==rs1 and rs1!=0, else rf_rs1_data; rs1==0 always yields 0; same for rs2.
REQ-019 Load-use hazard: hazard_stall=1 when id_ex_reg.valid, id_ex_reg.mem_read, id_ex_reg.rd!=0, and rd equals a source the current instruction uses (rs1 for all but LUI/AUIPC/JAL; rs2 for OP/STORE/BRANCH).
REQ-020 hazard_stall and not stall: next id_ex_reg is a bubble; if_id_reg is assumed held upstream and re-decoded next cycle.
REQ-021 stall=1: id_ex_reg holds its value; hazard_stall still evaluated against the held value.
REQ-022 flush=1: next id_ex_reg is a bubble regardless of stall or hazard_stall (flush has highest priority).
REQ-023 Priority per edge: reset > flush > stall > hazard bubble > normal decode.

Reset
REQ-024 reset=1 on an edge: id_ex_reg cleared to all zeros (valid=0); any in-progress hazard cleared.
REQ-025 During reset, hazard_stall=0 from the cycle after the reset edge onward while reset remains asserted.

Structure
REQ-026 ID_EX typedef, alu_op enum, and RV32I opcode constants belong in the shared pipeline_stage_registers package beside IF_ID.
REQ-027 Immediate extraction is a combinational sub-module imm_gen (inst in, format select in, 32-bit imm out).
REQ-028 The register file stays outside this block.

Verification
REQ-029 0x00500093 (addi x1,x0,5) -> next cycle valid=1, rd=1, rs1=0, imm=5, reg_write=1, rs1_val=0.
REQ-030 0x0000A103 (lw x2,0(x1)), then 0x001101B3 (add x3,x2,x1) -> hazard_stall=1 one cycle, one bubble, then add decoded with rs1=2, rs2=1.
REQ-031 0xFE000CE3 (beq x0,x0,-8) -> branch=1, imm=0xFFFFFFF8, reg_write=0, rd=0.
REQ-032 wb_we=1, wb_rd=1, wb_data=0xDEADBEEF, rf_rs1_data=0 with add reading x1 -> rs1_val=0xDEADBEEF; same with wb_rd=0 -> rs1_val=0.
REQ-033 flush and stall both asserted with valid instruction -> next id_ex_reg.valid=0; stall alone -> id_ex_reg unchanged for 3 cycles.
REQ-034 0xFFFFFFFF -> illegal=1, valid=1, all write/mem flags 0; reset asserted mid-stream -> id_ex_reg all zeros next edge.
